// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: frame geometry and the
// receiver state encoding (kept here so downstream benches can probe it).
package uart_rx_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 217;  // 25 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled by the system clock. Presents the
// last good byte with a level-style ready flag for a downstream word packer.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] uart_byte,
  output logic                 uart_byte_ready,
  output logic                 framing_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    ready_d   = ready_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        // The start edge is also the consume point for the previous byte.
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          if (!rx_s) begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            ready_d = 1'b1;
            err_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Wait out a held-low line so it is not read as a stream of start bits.
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign uart_byte       = byte_q;
  assign uart_byte_ready = ready_q;
  assign framing_err     = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit: a table of single frames
// followed by hand-written back-to-back, glitch, break and reset sequences.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] uart_byte;
  logic       uart_byte_ready;
  logic       framing_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .uart_byte      (uart_byte),
    .uart_byte_ready(uart_byte_ready),
    .framing_err    (framing_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_byte;
    logic       exp_ready;
    logic       exp_err;
  } frame_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame starting now (caller sits just after a clock edge).
  // Reports the cycle of the first ready rise and drop, counted from the
  // start-bit falling edge; 0 means it did not happen. The stop level is
  // left on the line when the task returns.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            output int rise, output int drop);
    logic [9:0] bits;
    logic       prev;
    int         cyc;
    bits = {stop, d, 1'b0};
    prev = uart_byte_ready;
    cyc  = 0;
    rise = 0;
    drop = 0;
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      repeat (CPB) begin
        @(posedge clk);
        #1;
        cyc++;
        if (uart_byte_ready && !prev && rise == 0) rise = cyc;
        if (!uart_byte_ready && prev && drop == 0) drop = cyc;
        prev = uart_byte_ready;
      end
    end
  endtask

  frame_vec_t vecs[6];

  initial begin
    int rise, drop, rise2, drop2, bad, seen_start;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0};

    // Reset with the line idle
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(2);
    check("reset uart_byte", 32'(uart_byte), 32'h00);
    check("reset ready", 32'(uart_byte_ready), 32'd0);
    check("reset framing_err", 32'(framing_err), 32'd0);
    check("reset state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    wait_cycles(4);

    // Table of single frames separated by idle time
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop, rise, drop);
      check($sformatf("vec%0d uart_byte", i), 32'(uart_byte), 32'(vecs[i].exp_byte));
      check($sformatf("vec%0d ready", i), 32'(uart_byte_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d framing_err", i), 32'(framing_err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_ready) begin
        check_range($sformatf("vec%0d ready latency", i), rise, 78, 80);
      end else begin
        check($sformatf("vec%0d ready rise", i), 32'(rise), 32'd0);
        check($sformatf("vec%0d state", i), 32'(dut.state_q), 32'(ST_BREAK));
      end
      rx = 1'b1;
      wait_cycles(12);
    end

    // Ready is a level: it must hold through a long idle stretch
    bad = 0;
    repeat (200) begin
      wait_cycles(1);
      if (!uart_byte_ready) bad++;
    end
    check("ready held over 200 idle cycles (drops)", 32'(bad), 32'd0);

    // Back-to-back frames, no idle between stop bit and next start bit
    send_frame(8'h3C, 1'b1, rise, drop);
    check("b2b first uart_byte", 32'(uart_byte), 32'h3C);
    check("b2b first ready", 32'(uart_byte_ready), 32'd1);
    send_frame(8'hC3, 1'b1, rise2, drop2);
    check("b2b ready drop cycle", 32'(drop2), 32'd3);
    check_range("b2b second ready latency", rise2, 78, 80);
    check("b2b second uart_byte", 32'(uart_byte), 32'hC3);
    check("b2b second ready", 32'(uart_byte_ready), 32'd1);
    wait_cycles(10);

    // Glitch: two low cycles only
    rx = 1'b0;
    wait_cycles(2);
    rx = 1'b1;
    bad = 0;
    repeat (20) begin
      wait_cycles(1);
      if (uart_byte_ready) bad++;
    end
    check("glitch ready high cycles", 32'(bad), 32'd0);
    check("glitch state", 32'(dut.state_q), 32'(ST_IDLE));
    check("glitch uart_byte kept", 32'(uart_byte), 32'hC3);
    send_frame(8'h11, 1'b1, rise, drop);
    check("after glitch uart_byte", 32'(uart_byte), 32'h11);
    check("after glitch ready", 32'(uart_byte_ready), 32'd1);
    wait_cycles(10);

    // Bad stop bit with the line held low for 24 cycles from the stop bit
    send_frame(8'hFF, 1'b0, rise, drop);
    seen_start = 0;
    repeat (16) begin
      wait_cycles(1);
      if (dut.state_q == ST_START) seen_start++;
    end
    check("break framing_err", 32'(framing_err), 32'd1);
    check("break ready", 32'(uart_byte_ready), 32'd0);
    check("break state", 32'(dut.state_q), 32'(ST_BREAK));
    check("break start entries", 32'(seen_start), 32'd0);
    check("break uart_byte kept", 32'(uart_byte), 32'h11);
    rx = 1'b1;
    wait_cycles(6);
    check("break release state", 32'(dut.state_q), 32'(ST_IDLE));
    send_frame(8'h01, 1'b1, rise, drop);
    check("after break uart_byte", 32'(uart_byte), 32'h01);
    check("after break framing_err", 32'(framing_err), 32'd0);
    check("after break ready", 32'(uart_byte_ready), 32'd1);
    wait_cycles(10);

    // Reset in the middle of data bit 4
    rx = 1'b0;
    wait_cycles(CPB + 4 * CPB + CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(1);
    check("midframe reset uart_byte", 32'(uart_byte), 32'h00);
    check("midframe reset ready", 32'(uart_byte_ready), 32'd0);
    check("midframe reset framing_err", 32'(framing_err), 32'd0);
    check("midframe reset state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    wait_cycles(10);
    send_frame(8'h5A, 1'b1, rise, drop);
    check("after reset uart_byte", 32'(uart_byte), 32'h5A);
    check("after reset ready", 32'(uart_byte_ready), 32'd1);
    check_range("after reset ready latency", rise, 78, 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
